// File: rtl/multicycle_seq_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state encoding,
// PC-select values, default memory timeout and the opcode legality helper.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic PC_SEL_PC4 = 1'b0;
  localparam logic PC_SEL_ALU = 1'b1;

  localparam int MEM_TIMEOUT_DEF = 15;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // JALR only exists with func3 == 0; every other opcode ignores func3.
  function automatic logic opcode_legal(input logic [4:0] op, input logic [2:0] f3);
    logic ok;
    case (op)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JAL: ok = 1'b1;
      OPC_JALR:                             ok = (f3 == 3'b000);
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_seq_if.sv
// Handshake/strobe bundle between the sequencer and the core datapath.
interface multicycle_seq_if;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic       b;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       ir_we;
  logic       pc_we;
  logic       pc_sel;
  logic       reg_wr;
  logic       mem_req;
  logic       we;
  logic       retired;
  logic       illegal;

  modport slave (
    input  opcode, func3, b, imem_ack, dmem_ack,
    output imem_req, ir_we, pc_we, pc_sel, reg_wr, mem_req, we, retired, illegal
  );

  modport master (
    output opcode, func3, b, imem_ack, dmem_ack,
    input  imem_req, ir_we, pc_we, pc_sel, reg_wr, mem_req, we, retired, illegal
  );
endinterface

// File: rtl/multicycle_seq_timer.sv
// Clear/increment wait counter; expired flags the last permitted wait cycle.
module multicycle_seq_timer #(
  parameter int TO_W  = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == TO_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Optional perf counters (cycle_cnt, instret_cnt) when MULTICYCLE_SEQ_PERF_EN is defined.
//   state    | meaning
//   S_FETCH  | imem_req high, wait for imem_ack, load IR
//   S_DECODE | legality check
//   S_EXEC   | branch resolves here; others dispatch to MEM or WB
//   S_MEM    | data access, bounded wait
//   S_WB     | register write and PC update
//   S_TRAP   | illegal instruction or memory timeout, held until rst
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_seq_if.slave   bus
`ifdef MULTICYCLE_SEQ_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  state_e state_q, state_d;
  logic   tmr_clr, tmr_inc, tmr_expired;
  logic   is_store, is_ls;

  assign is_store = (bus.opcode == OPC_STORE);
  assign is_ls    = is_store || (bus.opcode == OPC_LOAD);

  multicycle_seq_timer #(.TO_W(TO_W), .LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    tmr_clr      = 1'b0;
    tmr_inc      = 1'b0;
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_sel   = PC_SEL_PC4;
    bus.reg_wr   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.we       = 1'b0;
    bus.retired  = 1'b0;
    bus.illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: state_d = opcode_legal(bus.opcode, bus.func3) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (bus.opcode == OPC_BRANCH) begin
          bus.pc_we   = 1'b1;
          bus.pc_sel  = bus.b;
          bus.retired = 1'b1;
          state_d     = S_FETCH;
        end else if (is_ls) begin
          tmr_clr = 1'b1;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.we      = is_store;
        // An ack arriving in the expiry cycle takes priority over the trap.
        if (bus.dmem_ack) begin
          if (is_store) begin
            bus.pc_we   = 1'b1;
            bus.retired = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmr_expired) begin
          state_d = S_TRAP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_WB: begin
        bus.reg_wr  = 1'b1;
        bus.pc_we   = 1'b1;
        bus.retired = 1'b1;
        bus.pc_sel  = (bus.opcode == OPC_JAL || bus.opcode == OPC_JALR) ? PC_SEL_ALU : PC_SEL_PC4;
        state_d     = S_FETCH;
      end
      S_TRAP:  bus.illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

`ifdef MULTICYCLE_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_TRAP) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (bus.retired) instret_cnt_d = instret_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: per-cycle strobe vectors from a phase-based model.
module tb_multicycle_seq;

  localparam int TO = 15;

  localparam logic [4:0] LOAD = 5'b00000, OP_IMM = 5'b00100, AUIPC = 5'b00101,
                         STORE = 5'b01000, OP = 5'b01100, LUI = 5'b01101,
                         BRANCH = 5'b11000, JALR = 5'b11001, JAL = 5'b11011;

  // Vector bit positions: {imem_req, ir_we, pc_we, pc_sel, reg_wr, mem_req, we, retired, illegal}
  localparam logic [8:0] V_IMEM = 9'h100, V_IRWE = 9'h080, V_PCWE = 9'h040,
                         V_PCSEL = 9'h020, V_REGWR = 9'h010, V_MEMREQ = 9'h008,
                         V_WE = 9'h004, V_RET = 9'h002, V_ILL = 9'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_seq_if bus();

`ifdef MULTICYCLE_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
  multicycle_seq #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));
`else
  multicycle_seq #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.reg_wr,
            bus.mem_req, bus.we, bus.retired, bus.illegal};
  endfunction

  function automatic bit legal(input logic [4:0] op, input logic [2:0] f3);
    logic [4:0] ok_ops [9] = '{LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL};
    bit hit = 0;
    foreach (ok_ops[i]) if (ok_ops[i] == op) hit = 1;
    if (op == JALR && f3 != 3'b000) hit = 0;
    return hit;
  endfunction

  // Expected strobes at cycle k of an instruction: fetch waits iw cycles,
  // data memory acks after dw waits (dw >= TO means it never acks in time).
  function automatic logic [8:0] exp_vec(input int k, input logic [4:0] op, input logic [2:0] f3,
                                         input logic bv, input int iw, input int dw);
    int f = iw + 1;
    int m, memlen;
    logic [8:0] v = '0;
    bit st = (op == STORE);
    if (k < f) begin
      v = V_IMEM | ((k == iw) ? V_IRWE : 9'h000);
    end else if (k == f) begin
      v = '0;
    end else if (!legal(op, f3)) begin
      v = V_ILL;
    end else if (op == BRANCH) begin
      if (k == f + 1) v = V_PCWE | V_RET | (bv ? V_PCSEL : 9'h000);
    end else if (op == LOAD || op == STORE) begin
      if (k >= f + 2) begin
        m = k - (f + 2);
        memlen = (dw < TO) ? dw + 1 : TO;
        if (m < memlen) begin
          v = V_MEMREQ | (st ? V_WE : 9'h000);
          if (m == dw && st) v = v | V_PCWE | V_RET;
        end else if (dw >= TO) begin
          v = V_ILL;
        end else begin
          v = V_REGWR | V_PCWE | V_RET;
        end
      end
    end else if (k == f + 2) begin
      v = V_REGWR | V_PCWE | V_RET | ((op == JAL || op == JALR) ? V_PCSEL : 9'h000);
    end
    return v;
  endfunction

  task automatic pulse_reset(input string name);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq($sformatf("%s post_rst", name), 32'(obs()), 32'(V_IMEM));
    @(posedge clk); #1;
  endtask

  // Runs one instruction cycle-by-cycle; abort_k >= 0 asserts rst during that cycle.
  task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic bv,
                           input int iw, input int dw, input int abort_k, input string name);
    int f = iw + 1;
    int len;
    bit trapped = 0;
    bit ls = (op == LOAD || op == STORE);
    if (!legal(op, f3)) begin
      len = f + 4; trapped = 1;
    end else if (op == BRANCH) len = f + 2;
    else if (ls) begin
      if (dw >= TO) begin len = f + 2 + TO + 3; trapped = 1; end
      else len = f + 3 + dw + ((op == LOAD) ? 1 : 0);
    end else len = f + 3;
    bus.opcode = op;
    bus.func3  = f3;
    bus.b      = bv;
    for (int k = 0; k < len; k++) begin
      bus.imem_ack = (k == iw);
      bus.dmem_ack = ls && (k == f + 2 + dw);
      if (k == abort_k) rst = 1'b1;
      @(negedge clk);
      check_eq($sformatf("%s op=%b c%0d", name, op, k), 32'(obs()),
               32'(exp_vec(k, op, f3, bv, iw, dw)));
      @(posedge clk); #1;
      if (k == abort_k) begin
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check_eq($sformatf("%s abort", name), 32'(obs()), 32'(V_IMEM));
        @(posedge clk); #1;
        return;
      end
    end
    if (trapped) pulse_reset(name);
  endtask

  initial begin
    logic [4:0] pool [12] = '{LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL,
                              5'b11111, 5'b00001, 5'b10100};
    logic [4:0] op;
    logic [2:0] f3;
    int r, dw;

    bus.opcode = '0; bus.func3 = '0; bus.b = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_vec", 32'(obs()), 32'(V_IMEM));
`ifdef MULTICYCLE_SEQ_PERF_EN
    check_eq("reset_cycle_cnt", cycle_cnt, 32'd0);
    check_eq("reset_instret_cnt", instret_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    pulse_reset("align");

`ifdef MULTICYCLE_SEQ_PERF_EN
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 10; i++) run_instr(JAL, 3'd0, 1'b0, 0, 0, -1, "perf_jal");
    check_eq("perf_instret", instret_cnt, 32'd10);
    check_eq("perf_cycles", cycle_cnt, 32'd40);
    run_instr(5'b11111, 3'd0, 1'b0, 0, 0, -1, "perf_trap");
`endif

    run_instr(OP_IMM, 3'd0, 1'b0, 0, 0, -1, "addi");
    run_instr(BRANCH, 3'd1, 1'b1, 0, 0, -1, "br_taken");
    run_instr(BRANCH, 3'd1, 1'b0, 0, 0, -1, "br_not");
    run_instr(LOAD,   3'd2, 1'b0, 0, 3, -1, "load_w3");
    run_instr(STORE,  3'd2, 1'b0, 0, 99, -1, "store_to");
    run_instr(STORE,  3'd2, 1'b0, 0, 14, -1, "store_ack15");
    run_instr(LOAD,   3'd2, 1'b0, 0, 14, -1, "load_ack15");
    run_instr(5'b11111, 3'd0, 1'b0, 0, 0, -1, "bad_op");
    run_instr(JALR,   3'd3, 1'b0, 1, 0, -1, "jalr_f3");
    run_instr(JALR,   3'd0, 1'b0, 2, 0, -1, "jalr_ok");
    run_instr(LOAD,   3'd2, 1'b0, 0, 3, 4, "load_abort");
    run_instr(LUI,    3'd0, 1'b0, 0, 0, -1, "after_abort");

    for (int n = 0; n < 80; n++) begin
      op = pool[$urandom_range(0, 11)];
      f3 = 3'($urandom_range(0, 7));
      if (op == JALR && $urandom_range(0, 9) < 7) f3 = 3'd0;
      r = $urandom_range(0, 9);
      dw = (r < 7) ? (r % 5) : (r == 7) ? 14 : (r == 8) ? 13 : 20;
      run_instr(op, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 3), dw,
                ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
